crc5_usb_receiver: RTL and testbench
====================================

Name: crc5_usb_receiver

Overview:
- Receive side of the CRC-5-USB serial link. Accepts a 16-bit serial frame: 11 data bits, then 5 inverted-CRC bits.
- Deserialises the 11 data bits and checks the running CRC against the fixed USB residual.
- Reports data plus pass/fail once per frame.
- Sits directly after the line sampler, mirroring the CRC transmitter on the far end.

Parameters:
- ERR_CNT_W, 8, width of the optional saturating error counter (used only with CRC5_RX_ERRCNT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in  in  1  serial line bit, first bit = data MSB
- in_valid  in  1  `in` carries a frame bit this cycle; otherwise the cycle is ignored
- frame_start  in  1  qualified by in_valid; this bit is D0 of a new frame
- data  out  11  deserialised data, held between frames
- data_valid  out  1  one-cycle pulse: frame complete
- crc_ok  out  1  valid with data_valid: residual matched
- crc_err  out  1  valid with data_valid: residual mismatched
- err_count  out  ERR_CNT_W  present only with CRC5_RX_ERRCNT_EN

Behaviour:
- Clock and reset:
  - Reset is asynchronous, active-high; rst dominates all inputs.
  - Reset values: state=D0, crc=5'b11111, data=0, data_valid=0, crc_ok=0, crc_err=0, err_count=0.
- State machine: D0..D10, C0..C4 (16 states).
  - Advances one state per accepted bit (in_valid=1). C4 wraps to D0.
  - When in_valid=0: all state and CRC hold; data_valid=0.
- CRC register (MSB-first Galois, poly x^5+x^2+1 = 5'b00101). On each accepted bit:
  - fb = crc[4]^in
  - crc_next = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0)
  - Applies to all 16 bits, data and CRC alike.
- Data capture:
  - In D0..D10, the accepted bit shifts into an 11-bit shift register (MSB first).
  - The `data` output updates only at frame completion, so it stays stable between frames.
- Frame completion (bit accepted in C4):
  - On the next edge, data_valid=1 for exactly one cycle, and data <= shift register.
  - crc_ok = (crc_next == 5'b01100); crc_err = ~crc_ok.
  - crc reloads to 5'b11111 and state goes to D0 on the same edge.
- Latency: data_valid rises 1 cycle after the clock edge that samples the 16th bit.
- Back-to-back frames: D0 of the next frame may be accepted in the cycle data_valid is high, with no gap.
- frame_start:
  - With in_valid=1, forces the current bit to be treated as D0: the partial frame is discarded with no data_valid, crc is seeded from 5'b11111 with this bit, and state goes to D1.
  - Ignored when in_valid=0.
  - frame_start in state D0 is equivalent to a normal D0.
  - frame_start coinciding with a C4 bit: the restart wins, and no completion is reported.
- crc_ok and crc_err are only meaningful while data_valid=1; they are driven 0 otherwise.
- Reset mid-frame: the partial frame is lost and no pulse is produced.

Optional Feature:
- Macro: CRC5_RX_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - It increments on every data_valid with crc_err=1 and saturates at all-ones.
  - It is cleared only by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package crc5_usb_pkg:
  - Constants: DATA_W=11, CRC_W=5, FRAME_W=16, CRC5_POLY=5'b00101, CRC5_INIT=5'b11111, CRC5_RESIDUAL=5'b01100.
  - Typedef: frame-state enum (D0..C4, logic [3:0]).
  - Shared with the transmitter.
- Sub-module crc5_usb_lfsr:
  - 5-bit register with inputs en, seed (load INIT then shift this bit), in.
  - Outputs crc and crc_next.
  - Reusable by the transmitter.

Test Plan:
- Good frame, all-zero data:
  - Stimulus: bits 00000000000 then 01000, continuous in_valid, after reset.
  - Required: data=11'h000, data_valid pulse, crc_ok=1, crc_err=0, 1 cycle after the 16th bit.
- Corrupted frame:
  - Stimulus: same frame with CRC bit C1 flipped (00000000000 00000).
  - Required: data_valid=1, crc_ok=0, crc_err=1; err_count=1 if CRC5_RX_ERRCNT_EN is defined.
- Stalled frame:
  - Stimulus: the good frame with in_valid deasserted for 3 cycles after D5 and 1 cycle after C2.
  - Required: same result as the good-frame case, with the pulse delayed by 4 cycles.
- Back-to-back frames:
  - Stimulus: two good frames with no gap.
  - Required: two data_valid pulses exactly 16 cycles apart, both crc_ok=1.
- Restart:
  - Stimulus: 7 random bits, then frame_start=1 with the good frame.
  - Required: exactly one data_valid, crc_ok=1, data=11'h000.
- Mid-frame reset:
  - Stimulus: rst asserted asynchronously at C2.
  - Required: all outputs 0 immediately and no pulse; the next good frame passes.
- Error counter saturation: with ERR_CNT_W=2, five bad frames -> err_count=3.

Source files
------------

// File: rtl/crc5_usb_pkg.sv
// CRC-5-USB shared definitions for the serial receiver and transmitter.
// Latency: n/a (constants and a combinational helper). Backpressure: n/a.
// Frame layout: D0..D10 carry the data MSB first, then C0..C4 carry the inverted CRC.
package crc5_usb_pkg;

  localparam int DATA_W  = 11;
  localparam int CRC_W   = 5;
  localparam int FRAME_W = 16;

  localparam logic [CRC_W-1:0] CRC5_POLY     = 5'b00101;
  localparam logic [CRC_W-1:0] CRC5_INIT     = 5'b11111;
  localparam logic [CRC_W-1:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [3:0] {
    ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7,
    ST_D8, ST_D9, ST_D10, ST_C0, ST_C1, ST_C2, ST_C3, ST_C4
  } frame_state_t;

  // One MSB-first Galois step of x^5+x^2+1.
  function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc5_usb_lfsr.sv
// CRC-5-USB bit-serial register: shifts one bit per enabled cycle, seed restarts from INIT.
// Latency: crc_next is combinational, crc updates on the enabled edge. Backpressure: en=0 holds.
// clr reloads INIT on the enabled edge that closes a frame.
module crc5_usb_lfsr
  import crc5_usb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed,
  input  logic             clr,
  input  logic             in,
  output logic [CRC_W-1:0] crc,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] base;

  assign base     = seed ? CRC5_INIT : crc;
  assign crc_next = crc5_step(base, in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC5_INIT;
    end else if (en) begin
      crc <= clr ? CRC5_INIT : crc_next;
    end
  end

endmodule

// File: rtl/crc5_usb_receiver.sv
// CRC-5-USB frame receiver: deserialises 11 data bits and checks the 16-bit frame residual.
// Latency: data_valid is registered on the edge that samples bit 16. Backpressure: in_valid=0 stalls.
// Optional CRC5_RX_ERRCNT_EN adds a saturating err_count output of ERR_CNT_W bits.
module crc5_usb_receiver
  import crc5_usb_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              in_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              crc_ok,
  output logic              crc_err
`ifdef CRC5_RX_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  frame_state_t      state;
  logic [DATA_W-1:0] shreg;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  crc_next;
  logic              last_bit;
  logic              residual_ok;

  // A restart on the C4 bit wins, so completion needs frame_start low.
  assign last_bit    = in_valid && !frame_start && (state == ST_C4);
  assign residual_ok = (crc_next == CRC5_RESIDUAL);

  crc5_usb_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (in_valid),
    .seed     (frame_start),
    .clr      (last_bit),
    .in       (in),
    .crc      (crc_q),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_D0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      if (in_valid) begin
        if (frame_start) begin
          state <= ST_D1;
          shreg <= {{(DATA_W-1){1'b0}}, in};
        end else if (state == ST_C4) begin
          state      <= ST_D0;
          data       <= shreg;
          data_valid <= 1'b1;
          crc_ok     <= residual_ok;
          crc_err    <= !residual_ok;
        end else begin
          state <= frame_state_t'(state + 4'd1);
          if (state <= ST_D10) begin
            shreg <= {shreg[DATA_W-2:0], in};
          end
        end
      end
    end
  end

`ifdef CRC5_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (last_bit && !residual_ok && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_crc5_usb_receiver.sv
// Directed bench for crc5_usb_receiver with a frame-level scoreboard (define CRC5_RX_ERRCNT_EN for err_count).
`timescale 1ns/1ps
module tb_crc5_usb_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        frame_start;
  logic [10:0] data;
  logic        data_valid;
  logic        crc_ok;
  logic        crc_err;
`ifdef CRC5_RX_ERRCNT_EN
  logic [1:0]  err_count;
`endif

  crc5_usb_receiver #(.ERR_CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .data        (data),
    .data_valid  (data_valid),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err)
`ifdef CRC5_RX_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] d;
    logic        ok;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_cur;
  int          pulse_cycs[$];
  logic [10:0] hold = '0;
  int          exp_errs = 0;
  logic [10:0] last_data;
  logic        last_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Remainder of the data polynomial, with INIT folded into the top bits, divided by x^5+x^2+1.
  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [15:0] m;
    m = {d, 5'b0};
    m[15:11] = m[15:11] ^ 5'b11111;
    for (int i = 15; i >= 5; i--) begin
      if (m[i]) m[i-:6] = m[i-:6] ^ 6'b100101;
    end
    return m[4:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL pulse_missing: no data_valid at cycle %0d, required 1", q[0].cyc);
        void'(q.pop_front());
      end
      if (data_valid) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: data_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e_cur = q.pop_front();
          chk("pulse_data", {21'b0, data}, {21'b0, e_cur.d});
          chk("pulse_crc_ok", {31'b0, crc_ok}, {31'b0, e_cur.ok});
          chk("pulse_crc_err", {31'b0, crc_err}, {31'b0, !e_cur.ok});
          hold = e_cur.d;
          if (!e_cur.ok && exp_errs < 3) exp_errs++;
          pulse_cycs.push_back(cyc);
          last_data = data;
          last_ok   = crc_ok;
        end
      end else begin
        chk("idle_crc_ok", {31'b0, crc_ok}, 0);
        chk("idle_crc_err", {31'b0, crc_err}, 0);
        chk("data_hold", {21'b0, data}, {21'b0, hold});
      end
`ifdef CRC5_RX_ERRCNT_EN
      chk("err_count", {30'b0, err_count}, exp_errs);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles drive junk on in/frame_start to show they are ignored without in_valid.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid    = 1'b0;
      in          = 1'($urandom_range(0, 1));
      frame_start = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [10:0] d, input logic [4:0] c, input logic fs,
                            input int nbits, input int ga, input int gna,
                            input int gb, input int gnb);
    logic [15:0] bits;
    exp_t        e;
    bits = {d, c};
    for (int i = 0; i < nbits; i++) begin
      in          = bits[15-i];
      in_valid    = 1'b1;
      frame_start = fs && (i == 0);
      tick();
      in_valid    = 1'b0;
      frame_start = 1'b0;
      if (i == 15) begin
        e.d   = d;
        e.ok  = (c == ~crc5(d));
        e.cyc = cyc;
        q.push_back(e);
      end
      if (i == ga) idle(gna);
      if (i == gb) idle(gnb);
    end
  endtask

  task automatic good(input logic [10:0] d, input logic fs);
    send_frame(d, ~crc5(d), fs, 16, -1, 0, -1, 0);
  endtask

  task automatic drain();
    idle(20);
    chk("queue_drained", q.size(), 0);
  endtask

  int s;
  int np;

  initial begin
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
    #1;
    chk("rst_data", {21'b0, data}, 0);
    chk("rst_dv", {31'b0, data_valid}, 0);
    chk("rst_ok", {31'b0, crc_ok}, 0);
    chk("rst_err", {31'b0, crc_err}, 0);
    chk("model_pin_zero", {27'b0, crc5(11'h000)}, 32'h17);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // good all-zero frame: 00000000000 01000
    s = cyc;
    send_frame(11'h000, 5'b01000, 1'b0, 16, -1, 0, -1, 0);
    drain();
    chk("good_latency", pulse_cycs[$] - s, 16);
    chk("good_data", {21'b0, last_data}, 0);
    chk("good_ok", {31'b0, last_ok}, 1);

    // C1 flipped
    send_frame(11'h000, 5'b00000, 1'b0, 16, -1, 0, -1, 0);
    drain();
    chk("bad_ok", {31'b0, last_ok}, 0);
`ifdef CRC5_RX_ERRCNT_EN
    chk("bad_err_count", {30'b0, err_count}, 1);
`endif

    // stalls: 3 idle after D5, 1 idle after C2
    s = cyc;
    send_frame(11'h000, 5'b01000, 1'b0, 16, 5, 3, 13, 1);
    drain();
    chk("stall_latency", pulse_cycs[$] - s, 20);
    chk("stall_ok", {31'b0, last_ok}, 1);

    // back-to-back
    np = pulse_cycs.size();
    good(11'h000, 1'b0);
    good(11'h5A3, 1'b0);
    drain();
    chk("b2b_count", pulse_cycs.size() - np, 2);
    chk("b2b_spacing", pulse_cycs[$] - pulse_cycs[$-1], 16);

    // other data patterns, one corrupted
    good(11'h7FF, 1'b0);
    send_frame(11'h2C4, ~crc5(11'h2C4) ^ 5'b00001, 1'b0, 16, -1, 0, -1, 0);
    good(11'h001, 1'b1);
    drain();

    // restart after 7 random bits
    np = pulse_cycs.size();
    send_frame(11'($urandom), 5'($urandom), 1'b0, 7, -1, 0, -1, 0);
    send_frame(11'h000, 5'b01000, 1'b1, 16, -1, 0, -1, 0);
    drain();
    chk("restart_count", pulse_cycs.size() - np, 1);
    chk("restart_data", {21'b0, last_data}, 0);
    chk("restart_ok", {31'b0, last_ok}, 1);

    // restart on the C4 bit wins over completion
    np = pulse_cycs.size();
    send_frame(11'h123, ~crc5(11'h123), 1'b0, 15, -1, 0, -1, 0);
    send_frame(11'h000, 5'b01000, 1'b1, 16, -1, 0, -1, 0);
    drain();
    chk("c4_restart_count", pulse_cycs.size() - np, 1);
    chk("c4_restart_data", {21'b0, last_data}, 0);

    // mid-frame reset at C2
    good(11'h5A3, 1'b0);
    drain();
    np = pulse_cycs.size();
    send_frame(11'h000, 5'b01000, 1'b0, 13, -1, 0, -1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", {21'b0, data}, 0);
    chk("arst_dv", {31'b0, data_valid}, 0);
    chk("arst_ok", {31'b0, crc_ok}, 0);
    chk("arst_err", {31'b0, crc_err}, 0);
`ifdef CRC5_RX_ERRCNT_EN
    chk("arst_err_count", {30'b0, err_count}, 0);
`endif
    hold = '0;
    exp_errs = 0;
    tick();
    tick();
    rst = 1'b0;
    idle(5);
    chk("arst_no_pulse", pulse_cycs.size() - np, 0);
    good(11'h000, 1'b0);
    drain();
    chk("arst_then_good", {31'b0, last_ok}, 1);

    // five bad frames saturate a 2-bit counter
    for (int k = 0; k < 5; k++) send_frame(11'h000, 5'b00000, 1'b0, 16, -1, 0, -1, 0);
    drain();
`ifdef CRC5_RX_ERRCNT_EN
    chk("sat_err_count", {30'b0, err_count}, 3);
`endif
    chk("sat_last_ok", {31'b0, last_ok}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

endmodule
